// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_control
// Purpose  : Main control FSM of the multi-cycle CPU datapath. It moves each
//            instruction through fetch, decode, execute, memory and
//            writeback. It drives the datapath strobes and the two ALUOp bits
//            consumed by the downstream ALU control decoder. Memory phases
//            stall on mem_ready. Supported instructions are R-type, lw, sw
//            and beq; any other opcode raises a one-cycle illegal_instr pulse
//            in DECODE.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            opcode[6:0]       - instruction register opcode (valid from DECODE)
//            alu_zero          - ALU zero flag (PC gating is done in datapath)
//            mem_ready         - memory access completes this cycle
//            PCWrite .. ALUOp1 - datapath control strobes
//            illegal_instr     - unsupported opcode pulse
//            state_dbg[3:0]    - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_control #(
    parameter logic [6:0] OP_RTYPE = 7'b0110011,
    parameter logic [6:0] OP_LW    = 7'b0000011,
    parameter logic [6:0] OP_SW    = 7'b0100011,
    parameter logic [6:0] OP_BEQ   = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic       ALUOp0,
    output logic       ALUOp1,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    localparam logic [1:0] c_SRCB_REG    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_BROFF  = 2'b11;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    state_t state_q;
    state_t state_d;

    // Decoded (pre-reset-gating) control values
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_pc_source;
    logic [1:0] w_alu_op;
    logic       w_illegal;

    // The branch decision (PCWriteCond & alu_zero) is resolved in the
    // datapath, so the zero flag does not steer this FSM.
    logic w_unused_alu_zero;
    assign w_unused_alu_zero = alu_zero;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = c_SRCB_REG;
        w_pc_source     = 1'b0;
        w_alu_op        = c_ALUOP_ADD;
        w_illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed while the instruction is read; IR and PC
                // only commit on the cycle the memory actually returns.
                w_mem_read  = 1'b1;
                w_alu_src_b = c_SRCB_FOUR;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                w_alu_src_b = c_SRCB_BROFF;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else begin
                    w_illegal = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = c_SRCB_IMM;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    // Opcode changed under us; abandon the instruction
                    state_d = S_FETCH;
                end
            end

            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                state_d    = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                state_d     = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = c_SRCB_REG;
                w_alu_op    = c_ALUOP_FUNCT;
                state_d     = S_RWB;
            end

            S_RWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b0;
                state_d      = S_FETCH;
            end

            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = c_SRCB_REG;
                w_alu_op        = c_ALUOP_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 1'b1;
                state_d         = S_FETCH;
            end

            default: begin
                // Encodings 9..15: recover to FETCH with everything idle
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: every strobe is forced low while reset is asserted so a
    // reset in the middle of a memory access cannot leak a request.
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite       = ~rst & w_pc_write;
        PCWriteCond   = ~rst & w_pc_write_cond;
        IorD          = ~rst & w_iord;
        MemRead       = ~rst & w_mem_read;
        MemWrite      = ~rst & w_mem_write;
        IRWrite       = ~rst & w_ir_write;
        MemtoReg      = ~rst & w_mem_to_reg;
        RegWrite      = ~rst & w_reg_write;
        ALUSrcA       = ~rst & w_alu_src_a;
        ALUSrcB       = rst ? 2'b00 : w_alu_src_b;
        PCSource      = ~rst & w_pc_source;
        ALUOp0        = ~rst & w_alu_op[0];
        ALUOp1        = ~rst & w_alu_op[1];
        illegal_instr = ~rst & w_illegal;
        state_dbg     = state_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_main_control
// Purpose  : Self-checking bench for multicycle_main_control. A driver applies
//            one cycle of inputs at a time and pushes the expected state and
//            control vector into a scoreboard; a monitor pops and compares on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_control;

    localparam logic [6:0] c_RT  = 7'b0110011;
    localparam logic [6:0] c_LW  = 7'b0000011;
    localparam logic [6:0] c_SW  = 7'b0100011;
    localparam logic [6:0] c_BEQ = 7'b1100011;
    localparam logic [6:0] c_BAD = 7'b1111111;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4;
    localparam logic [3:0] MW = 4'd5, EX = 4'd6, RB = 4'd7, BR = 4'd8;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, ALUSrcA, PCSource, ALUOp0, ALUOp1;
    logic       illegal_instr;
    logic [1:0] ALUSrcB;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] outs;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    multicycle_main_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .PCSource      (PCSource),
        .ALUOp0        (ALUOp0),
        .ALUOp1        (ALUOp1),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit order of the control vector:
    // 14 PCWrite 13 PCWriteCond 12 IorD 11 MemRead 10 MemWrite 9 IRWrite
    // 8 MemtoReg 7 RegWrite 6 ALUSrcA 5:4 ALUSrcB 3 PCSource 2 ALUOp1
    // 1 ALUOp0 0 illegal_instr
    logic [15:0] w_obs;
    assign w_obs = {1'b0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp1,
                    ALUOp0, illegal_instr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected control vector for one cycle, written from the state table
    function automatic logic [15:0] exp_out(input logic [3:0] st, input logic mr,
                                            input logic [6:0] op, input logic r);
        logic [15:0] v;
        v = 16'h0000;
        if (r) return v;
        case (st)
            FE: begin v[11] = 1'b1; v[5:4] = 2'b01; v[9] = mr; v[14] = mr; end
            DE: begin
                v[5:4] = 2'b11;
                if (!(op == c_RT || op == c_LW || op == c_SW || op == c_BEQ)) v[0] = 1'b1;
            end
            MA: begin v[6] = 1'b1; v[5:4] = 2'b10; end
            MR: begin v[11] = 1'b1; v[12] = 1'b1; end
            MB: begin v[7] = 1'b1; v[8] = 1'b1; end
            MW: begin v[10] = 1'b1; v[12] = 1'b1; end
            EX: begin v[6] = 1'b1; v[2] = 1'b1; end
            RB: begin v[7] = 1'b1; end
            BR: begin v[6] = 1'b1; v[1] = 1'b1; v[13] = 1'b1; v[3] = 1'b1; end
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Drive one cycle of inputs and record what the DUT must show this cycle
    task automatic step(input string tag, input logic [6:0] op, input logic mr,
                        input logic az, input logic r, input logic [3:0] es);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        alu_zero  = az;
        rst       = r;
        e.st      = es;
        e.outs    = exp_out(es, mr, op, r);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare mid-cycle, away from the rising edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".state"}, {28'd0, state_dbg}, {28'd0, e.st});
            check({t, ".ctrl"}, {16'd0, w_obs}, {16'd0, e.outs});
            check({t, ".rd_wr_excl"}, {31'd0, MemRead & MemWrite}, 32'd0);
            check({t, ".rw_pcw_excl"}, {31'd0, RegWrite & PCWrite}, 32'd0);
            check({t, ".aluop11"}, {31'd0, ALUOp1 & ALUOp0}, 32'd0);
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; opcode = 7'd0; alu_zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset held two cycles
        step("rst0", c_RT, 1'b1, 1'b0, 1'b1, FE);
        step("rst1", c_RT, 1'b1, 1'b0, 1'b1, FE);

        // R-type
        step("rt_fe", c_RT, 1'b1, 1'b0, 1'b0, FE);
        step("rt_de", c_RT, 1'b1, 1'b0, 1'b0, DE);
        step("rt_ex", c_RT, 1'b1, 1'b0, 1'b0, EX);
        step("rt_wb", c_RT, 1'b1, 1'b0, 1'b0, RB);

        // lw with three stall cycles in MEMRD
        step("lw_fe", c_LW, 1'b1, 1'b0, 1'b0, FE);
        step("lw_de", c_LW, 1'b1, 1'b0, 1'b0, DE);
        step("lw_ma", c_LW, 1'b1, 1'b0, 1'b0, MA);
        for (int i = 0; i < 3; i++) step("lw_rd_stall", c_LW, 1'b0, 1'b0, 1'b0, MR);
        step("lw_rd", c_LW, 1'b1, 1'b0, 1'b0, MR);
        step("lw_wb", c_LW, 1'b1, 1'b0, 1'b0, MB);

        // sw, one stall
        step("sw_fe", c_SW, 1'b1, 1'b0, 1'b0, FE);
        step("sw_de", c_SW, 1'b1, 1'b0, 1'b0, DE);
        step("sw_ma", c_SW, 1'b1, 1'b0, 1'b0, MA);
        step("sw_wr_stall", c_SW, 1'b0, 1'b0, 1'b0, MW);
        step("sw_wr", c_SW, 1'b1, 1'b0, 1'b0, MW);

        // beq taken and not taken: identical strobes
        for (int z = 1; z >= 0; z--) begin
            step("beq_fe", c_BEQ, 1'b1, 1'(z), 1'b0, FE);
            step("beq_de", c_BEQ, 1'b1, 1'(z), 1'b0, DE);
            step("beq_br", c_BEQ, 1'b1, 1'(z), 1'b0, BR);
        end

        // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
        step("ill_fe", c_BAD, 1'b1, 1'b0, 1'b0, FE);
        step("ill_de", c_BAD, 1'b1, 1'b0, 1'b0, DE);
        step("ill_after", c_BAD, 1'b0, 1'b0, 1'b0, FE);

        // FETCH stall for two cycles, then R-type completes
        step("fs_stall", c_RT, 1'b0, 1'b0, 1'b0, FE);
        step("fs_stall", c_RT, 1'b1, 1'b0, 1'b0, FE);
        step("fs_de", c_RT, 1'b1, 1'b0, 1'b0, DE);
        step("fs_ex", c_RT, 1'b1, 1'b0, 1'b0, EX);
        step("fs_wb", c_RT, 1'b1, 1'b0, 1'b0, RB);

        // Reset in the middle of a stalled load
        step("mr_fe", c_LW, 1'b1, 1'b0, 1'b0, FE);
        step("mr_de", c_LW, 1'b1, 1'b0, 1'b0, DE);
        step("mr_ma", c_LW, 1'b1, 1'b0, 1'b0, MA);
        step("mr_rd", c_LW, 1'b0, 1'b0, 1'b0, MR);
        step("mr_rst0", c_LW, 1'b0, 1'b0, 1'b1, MR);
        step("mr_rst1", c_LW, 1'b1, 1'b0, 1'b1, FE);
        step("mr_rel", c_LW, 1'b1, 1'b0, 1'b0, FE);
        step("mr_rel_de", c_LW, 1'b1, 1'b0, 1'b0, DE);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
